f_fetch_unit: RTL and testbench
===============================

F_FETCH_UNIT -- requirements
Module: f_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word address of the outstanding request.
REQ-006 SHALL have port imem_ack  input  1  memory returns data this cycle; ignored while imem_req=0.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port redirect  input  1  decode-stage control flow taken (beq taken, jal, jr).
REQ-009 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-010 SHALL have port d_ready  input  1  decode stage accepts the presented instruction (0 = stall).
REQ-011 SHALL have port d_valid  output  1  d_instr/d_pc hold a live instruction.
REQ-012 SHALL have port d_instr  output  32  instruction to decode (opcode [31:26], func [5:0]).
REQ-013 SHALL have port d_pc  output  32  address of d_instr.
REQ-014 SHALL have port d_pc8  output  32  d_pc+8 (jal link value), modulo 2^32.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, FULL, DROP; reset state IDLE.
REQ-016 IDLE: imem_req=0; unconditionally to REQ next cycle.
REQ-017 REQ and DROP: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-018 FULL: imem_req=0.
REQ-019 Output register, 1 entry (d_valid/d_instr/d_pc); skid buffer, 1 entry; a transfer to decode occurs when d_valid=1 and d_ready=1.
REQ-020 REQ + ack, no redirect: data captured into output register if it is empty or transfers this cycle, else into skid and next state FULL; pc<=pc+4 (modulo 2^32); stay in REQ when not going FULL.
REQ-021 FULL + transfer: skid moves into output register same edge; next state REQ.
REQ-022 Instructions SHALL reach decode in address order with none duplicated or lost.
REQ-023 The core has no branch delay slot: redirect=1 invalidates the output register and skid at the next edge (d_valid<=0).
REQ-024 redirect in REQ without ack: pc<=redirect_pc, next state DROP; the request in flight is kept, its address unchanged.
REQ-025 DROP: on ack, data discarded and next state REQ at the already-loaded pc; further redirect in DROP overwrites pc, stays DROP.
REQ-026 redirect coincident with ack in REQ: data discarded, pc<=redirect_pc, stay REQ (new address next cycle).
REQ-027 redirect in FULL or IDLE: pc<=redirect_pc, buffers cleared, next state REQ.
REQ-028 Minimum latency: ack in cycle N -> d_valid=1 in N+1; back-to-back single-cycle acks SHALL give one instruction per cycle with d_ready=1.
REQ-029 d_pc8 SHALL be combinational d_pc+8 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0004).
REQ-030 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-031 reset=1 SHALL override all inputs, incl. an outstanding request and a simultaneous redirect.
REQ-032 After the reset edge: state IDLE, pc=RESET_PC, imem_req=0, d_valid=0, d_instr=0, d_pc=0, skid empty, d_pc8=8.
REQ-033 A request abandoned by reset SHALL not be re-issued; a late ack during IDLE SHALL be ignored.

Verification
REQ-034 Reset, ack every cycle, d_ready=1 -> imem_addr 3000,3004,3008; d_pc 3000,3004,3008 on consecutive cycles, d_pc8=3008 for first.
REQ-035 ack at 3004 while d_ready=0 -> state FULL, imem_req=0; d_ready=1 -> d_pc 3000 then 3004, next request 3008.
REQ-036 redirect with redirect_pc=32'h0000_3403 while 3008 unacked -> imem_addr stays 3008 until ack, data dropped, next imem_addr 3400, next d_pc 3400.
REQ-037 redirect and ack same cycle (addr 300C, redirect_pc 3100) -> 300C never reaches decode, next imem_addr 3100.
REQ-038 reset asserted mid-request (addr 3010) -> imem_req=0 next cycle, d_valid=0, first new request at 3000.
REQ-039 pc=32'hFFFF_FFFC fetch -> d_pc8=32'h0000_0004, next imem_addr 32'h0000_0000.

Source files
------------

// File: rtl/f_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and the decode stage.
interface f_fetch_unit_if;
  // imem: imem_req/imem_addr hold steady until the cycle imem_ack=1 completes the read.
  // decode: an instruction moves when d_valid=1 and d_ready=1 on the same rising edge.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;

  modport master (
    output imem_req, imem_addr, d_valid, d_instr, d_pc, d_pc8,
    input  imem_ack, imem_rdata, redirect, redirect_pc, d_ready
  );

  modport slave (
    input  imem_req, imem_addr, d_valid, d_instr, d_pc, d_pc8,
    output imem_ack, imem_rdata, redirect, redirect_pc, d_ready
  );
endinterface

// File: rtl/f_fetch_unit.sv
// Instruction fetch: one outstanding imem read, a one-entry output register plus a
// one-entry skid buffer toward decode, and redirect handling without a delay slot.
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset,
  f_fetch_unit_if.master        bus,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FULL = 2'd2, DROP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        xfer;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign xfer     = out_valid_q & bus.d_ready;
  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc   = pc_q + 32'd4;

  // The skid entry is occupied exactly while the FSM sits in FULL.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (xfer) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect) pc_d = redir_pc;
      end
      REQ: begin
        if (bus.redirect) begin
          pc_d = redir_pc;
          if (!bus.imem_ack) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (bus.imem_ack) begin
          pc_d = pc_inc;
          if (!out_valid_q || xfer) begin
            out_valid_d = 1'b1;
            out_instr_d = bus.imem_rdata;
            out_pc_d    = pc_q;
          end else begin
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = FULL;
          end
        end
      end
      FULL: begin
        if (bus.redirect) begin
          pc_d    = redir_pc;
          state_d = REQ;
        end else if (xfer) begin
          out_valid_d = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          state_d     = REQ;
        end
      end
      DROP: begin
        // The stale read must still complete; only then is the new pc requested.
        if (bus.redirect) pc_d = redir_pc;
        if (bus.imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 32'd0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'd0;
      out_pc_q     <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign bus.imem_req  = (state_q == REQ) || (state_q == DROP);
  assign bus.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign bus.d_valid   = out_valid_q;
  assign bus.d_instr   = out_instr_q;
  assign bus.d_pc      = out_pc_q;
  assign bus.d_pc8     = out_pc_q + 32'd8;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed scenarios with literal expectations plus a random
// run, all checked every cycle against a queue-based model of the fetch stream.
module tb_f_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  f_fetch_unit_if bus ();

  f_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A5A};
  endfunction

  // ---------------- behavioural model / scoreboard ----------------
  // exp_q holds {pc, instr} of fetched instructions not yet taken by decode (at most 2).
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  logic        m_idle;
  logic        m_stale;
  logic        m_known = 1'b0;
  logic        m_req;
  logic        c_req;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_pc    = RESET_PC;
      m_idle  = 1'b1;
      m_stale = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      m_req = !m_idle && (exp_q.size() < 2);
      if (exp_q.size() > 0 && bus.d_ready) void'(exp_q.pop_front());
      if (bus.redirect) begin
        exp_q.delete();
        if (m_req && !bus.imem_ack) begin
          if (!m_stale) m_stale_addr = m_pc;
          m_stale = 1'b1;
        end else begin
          m_stale = 1'b0;
        end
        m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else if (m_req && bus.imem_ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          exp_q.push_back({m_pc, bus.imem_rdata});
          m_pc = m_pc + 32'd4;
        end
      end
      m_idle = 1'b0;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      c_req = !m_idle && (exp_q.size() < 2);
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, c_req});
      if (c_req) chk("imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
      chk("d_valid", {31'd0, bus.d_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        chk("d_pc", bus.d_pc, exp_q[0][63:32]);
        chk("d_instr", bus.d_instr, exp_q[0][31:0]);
        chk("d_pc8", bus.d_pc8, exp_q[0][63:32] + 32'd8);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ack, input logic rdy, input logic redir,
                       input logic [31:0] rpc);
    bus.imem_ack    = ack;
    bus.imem_rdata  = ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
    bus.d_ready     = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.d_ready     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rpc;

  initial begin
    do_reset();
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("rst_instr", bus.d_instr, 32'd0);
    chk("rst_pc", bus.d_pc, 32'd0);
    chk("rst_pc8", bus.d_pc8, 32'd8);

    // Streaming with an ack every cycle.
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("s_addr0", bus.imem_addr, 32'h3000);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("s_dpc0", bus.d_pc, 32'h3000);
    chk("s_dpc8_0", bus.d_pc8, 32'h3008);
    chk("s_addr1", bus.imem_addr, 32'h3004);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("s_dpc1", bus.d_pc, 32'h3004);
    chk("s_addr2", bus.imem_addr, 32'h3008);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("s_dpc2", bus.d_pc, 32'h3008);
    chk("s_addr3", bus.imem_addr, 32'h300C);

    // Redirect coincident with ack at 300C.
    drive(1'b1, 1'b1, 1'b1, 32'h3100);
    chk("ra_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("ra_addr", bus.imem_addr, 32'h3100);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("ra_dpc", bus.d_pc, 32'h3100);

    // Decode stall fills the skid buffer.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("st_dpc0", bus.d_pc, 32'h3000);
    chk("st_addr1", bus.imem_addr, 32'h3004);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    chk("st_full", {30'd0, dbg_state}, 32'd2);
    chk("st_noreq", {31'd0, bus.imem_req}, 32'd0);
    chk("st_hold", bus.d_pc, 32'h3000);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("st_dpc1", bus.d_pc, 32'h3004);
    chk("st_req", {31'd0, bus.imem_req}, 32'd1);
    chk("st_addr2", bus.imem_addr, 32'h3008);

    // Redirect while 3008 is outstanding.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3403);
    chk("dr_state", {30'd0, dbg_state}, 32'd3);
    chk("dr_addr0", bus.imem_addr, 32'h3008);
    chk("dr_valid", {31'd0, bus.d_valid}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk("dr_addr1", bus.imem_addr, 32'h3008);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("dr_drop", {31'd0, bus.d_valid}, 32'd0);
    chk("dr_addr2", bus.imem_addr, 32'h3400);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("dr_dpc", bus.d_pc, 32'h3400);

    // Reset during a request, with a redirect and ack in the same cycle.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("mr_addr", bus.imem_addr, 32'h3010);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_5000);
    chk("mr_req", {31'd0, bus.imem_req}, 32'd0);
    chk("mr_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("mr_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("mr_addr0", bus.imem_addr, 32'h3000);
    chk("mr_late", {31'd0, bus.d_valid}, 32'd0);

    // Address wrap at the top of memory.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wr_dpc", bus.d_pc, 32'hFFFF_FFFC);
    chk("wr_dpc8", bus.d_pc8, 32'h0000_0004);
    chk("wr_next", bus.imem_addr, 32'h0000_0000);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else rpc = 32'h0000_3000 + $urandom_range(0, 4095);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 8, rpc);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
